bcd_down_timer: RTL and testbench
=================================

Name: bcd_down_timer

Overview:
- Multi-digit BCD down-counter/timer. It is the counting-down counterpart of the team's BCD up-counter.
- Loads a BCD preset, decrements by one on each enabled clock, and flags terminal zero with a registered one-cycle done pulse.
- Used as a countdown/timeout source alongside the up-counter; digits are exposed directly for 7-segment decode.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); counter width is 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- load  input  1  synchronous preset strobe.
- load_value  input  4*DIGITS  BCD preset, digit 0 in [3:0].
- start  input  1  begin/resume counting.
- pause  input  1  suspend counting.
- down_enable  input  1  decrement qualifier (tick).
- bcd  output  4*DIGITS  current count, registered.
- zero  output  1  combinational, 1 when bcd == 0.
- done  output  1  registered one-cycle pulse on reaching zero.
- busy  output  1  1 in RUN or HOLD.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - bcd=0, state=IDLE, done=0, busy=0, zero=1.
- States: IDLE, RUN, HOLD, DONE. State is registered and busy is decoded from it.
- Priority each edge: reset > load > pause > start > down_enable.
- load (any state):
  - bcd <= sanitized load_value; state <= IDLE; done <= 0; start and pause are ignored that cycle.
  - Sanitize: any digit nibble > 9 is loaded as 9 (e.g. 8'h3A -> 8'h39).
- IDLE:
  - start with bcd != 0 -> RUN at that edge. No decrement on the start edge; the first decrement occurs at the next edge with down_enable=1.
  - start with bcd == 0 -> DONE, done=1 for that one cycle, bcd unchanged.
- RUN:
  - On each edge with down_enable=1, bcd decrements by 1 in BCD.
  - Per-digit borrow chain: a digit at 0 receiving a borrow becomes 9 and propagates the borrow; otherwise it decrements and stops the borrow.
  - When the decrement takes bcd from 1 to 0 -> state DONE and done=1 in the same cycle bcd first reads 0. done returns to 0 on the next edge.
  - down_enable=0 -> hold the value, stay in RUN.
  - pause=1 -> HOLD with no decrement that edge, even if down_enable=1.
- HOLD:
  - bcd frozen regardless of down_enable.
  - start with pause=0 -> RUN (no decrement on that edge).
  - pause and start together -> stay in HOLD.
- DONE:
  - bcd stays 0 and never wraps to 9..9; start and down_enable are ignored.
  - Exit only via load (-> IDLE) or reset.
- Reset asserted mid-count: immediate clear to the reset values; on deassertion, resume from IDLE with bcd=0.
- No binary arithmetic on the full vector. All arithmetic is per-digit 4-bit; the counter value is always a valid BCD code.

Decomposition:
- Shared package (bcd_pkg):
  - state encoding constants: IDLE=2'd0, RUN=2'd1, HOLD=2'd2, DONE=2'd3;
  - BCD_MAX=4'd9;
  - digit sanitize function (nibble > 9 -> 9).
- Sub-module bcd_down_digit:
  - ports: clk, reset, load, d[3:0], borrow_in, q[3:0], borrow_out;
  - borrow_out = borrow_in && q==0;
  - wraps 0->9 on borrow.
- Top level instantiates DIGITS copies via generate. Digit 0 borrow_in = (state==RUN && down_enable && !pause && !load); each following digit takes the previous digit's borrow_out.

Test Plan (DIGITS=2):
- Reset: hold reset=0 for 20ns, then release -> bcd=8'h00, zero=1, done=0, busy=0, state IDLE; no clock edge required for the clear.
- Full countdown: load 8'h12, pulse start, then down_enable=1 continuously -> bcd=8'h12, 11, 10, 09, ..., 01, 00 on successive edges. done=1 only in the cycle bcd becomes 00 (12 decrement edges after start); busy falls in that same cycle; bcd stays 00 for a further 20 cycles.
- Sanitize and borrow: load 8'h3A -> bcd=8'h39. Load 8'h10, start, one tick -> 8'h09 (digit1 borrow, digit0 wraps to 9).
- Pause: during RUN at bcd=8'h05, assert pause with down_enable=1 for 5 cycles -> bcd holds 05 and busy=1. Then start with pause=0 -> next ticks give 04, 03.
- Start at zero: after reset, pulse start -> done=1 for exactly one cycle, bcd=00, state DONE. A further start has no effect. load 8'h02 -> IDLE, done=0.
- Async reset mid-run at bcd=8'h07: drive reset=0 between clock edges -> bcd=00 immediately. Simultaneous load and start -> load wins and state stays IDLE.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD down-timer: FSM state encoding, digit limit
// and the preset digit clamp.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] bcd_sanitize(input logic [3:0] nib);
        return (nib > BCD_MAX) ? BCD_MAX : nib;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter: synchronous preset, decrement on borrow_in,
// wraps 0 -> 9 and passes the borrow on when it does.
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] d,
    input  logic       borrow_in,
    output logic [3:0] q,
    output logic       borrow_out
);

    logic [3:0] q_d;
    logic [3:0] q_q;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (borrow_in) begin
            q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q          = q_q;
    assign borrow_out = borrow_in && (q_q == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with load/start/pause control and a
// registered one-cycle done pulse on reaching zero.
module bcd_down_timer
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    input  logic                start,
    input  logic                pause,
    input  logic                down_enable,
    output logic [4*DIGITS-1:0] bcd,
    output logic                zero,
    output logic                done,
    output logic                busy
);

    state_e              state_d, state_q;
    logic                done_d, done_q;
    logic [4*DIGITS-1:0] load_san;
    logic [DIGITS:0]     borrow;
    logic                dec;
    logic                is_one;

    always_comb begin
        load_san = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_san[4*i +: 4] = bcd_sanitize(load_value[4*i +: 4]);
        end
    end

    assign dec       = (state_q == RUN) && down_enable && !pause && !load;
    assign borrow[0] = dec;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_down_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .load       (load),
            .d          (load_san[4*g +: 4]),
            .borrow_in  (borrow[g]),
            .q          (bcd[4*g +: 4]),
            .borrow_out (borrow[g+1])
        );
    end

    assign zero   = (bcd == '0);
    assign is_one = (bcd == (4*DIGITS)'(1));

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!pause && start) begin
                        if (zero) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = HOLD;
                    // a borrow out of the top digit would be an underflow; treat it as terminal too
                    end else if (dec && (is_one || borrow[DIGITS])) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                HOLD: begin
                    if (!pause && start) begin
                        state_d = RUN;
                    end
                end
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
    assign busy = (state_q == RUN) || (state_q == HOLD);

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer (DIGITS=2): vector table, corner-case
// sequences and randomized traffic against an integer-valued reference model.
module tb_bcd_down_timer;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] load_value;
    logic         start;
    logic         pause;
    logic         down_enable;
    logic [W-1:0] bcd;
    logic         zero;
    logic         done;
    logic         busy;

    int checks = 0;
    int errors = 0;

    bcd_down_timer #(.DIGITS(DIGITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .start       (start),
        .pause       (pause),
        .down_enable (down_enable),
        .bcd         (bcd),
        .zero        (zero),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // reference model: count held as a plain integer 0..99
    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;
    int m_val  = 0;
    int m_st   = M_IDLE;
    bit m_done = 1'b0;

    function automatic logic [W-1:0] to_bcd(input int v);
        return W'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int from_preset(input logic [W-1:0] lv);
        int lo, hi;
        lo = int'(lv[3:0]);
        hi = int'(lv[7:4]);
        if (lo > 9) lo = 9;
        if (hi > 9) hi = 9;
        return hi * 10 + lo;
    endfunction

    task automatic model_reset();
        m_val  = 0;
        m_st   = M_IDLE;
        m_done = 1'b0;
    endtask

    task automatic model_step();
        m_done = 1'b0;
        if (load) begin
            m_val = from_preset(load_value);
            m_st  = M_IDLE;
        end else begin
            case (m_st)
                M_IDLE: if (!pause && start) begin
                    if (m_val == 0) begin
                        m_st   = M_DONE;
                        m_done = 1'b1;
                    end else begin
                        m_st = M_RUN;
                    end
                end
                M_RUN: if (pause) begin
                    m_st = M_HOLD;
                end else if (down_enable) begin
                    m_val = m_val - 1;
                    if (m_val == 0) begin
                        m_st   = M_DONE;
                        m_done = 1'b1;
                    end
                end
                M_HOLD: if (!pause && start) m_st = M_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, " bcd"},  32'(bcd),  32'(to_bcd(m_val)));
        chk({tag, " zero"}, 32'(zero), 32'(m_val == 0));
        chk({tag, " done"}, 32'(done), 32'(m_done));
        chk({tag, " busy"}, 32'(busy), 32'(m_st == M_RUN || m_st == M_HOLD));
    endtask

    task automatic drive(input logic ld, input logic [W-1:0] lv, input logic st,
                         input logic pa, input logic de);
        load        = ld;
        load_value  = lv;
        start       = st;
        pause       = pa;
        down_enable = de;
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    typedef struct {
        logic         ld;
        logic [W-1:0] lv;
        logic         st;
        logic         pa;
        logic         de;
        logic [W-1:0] e_bcd;
        logic         e_done;
        logic         e_busy;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // load, value, start, pause, tick -> bcd, done, busy
        vecs.push_back('{1, 8'h3A, 0, 0, 0, 8'h39, 0, 0});
        vecs.push_back('{1, 8'h10, 0, 0, 0, 8'h10, 0, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 1, 8'h10, 0, 1});
        vecs.push_back('{0, 8'h00, 0, 0, 1, 8'h09, 0, 1});
        vecs.push_back('{0, 8'h00, 0, 0, 1, 8'h08, 0, 1});
        vecs.push_back('{0, 8'h00, 0, 1, 1, 8'h08, 0, 1});
        vecs.push_back('{0, 8'h00, 1, 1, 1, 8'h08, 0, 1});
        vecs.push_back('{0, 8'h00, 1, 0, 1, 8'h08, 0, 1});
        vecs.push_back('{0, 8'h00, 0, 0, 1, 8'h07, 0, 1});
        vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h07, 0, 1});
        vecs.push_back('{1, 8'h12, 1, 0, 1, 8'h12, 0, 0});
        vecs.push_back('{1, 8'h01, 0, 0, 0, 8'h01, 0, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 0, 8'h01, 0, 1});
        vecs.push_back('{0, 8'h00, 0, 0, 1, 8'h00, 1, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 1, 8'h00, 0, 0});
        vecs.push_back('{1, 8'h02, 0, 0, 0, 8'h02, 0, 0});
        vecs.push_back('{1, 8'hFF, 0, 0, 0, 8'h99, 0, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 1, 8'h99, 0, 1});
        vecs.push_back('{0, 8'h00, 0, 0, 1, 8'h98, 0, 1});
    end

    initial begin
        reset = 1'b0;
        drive(0, '0, 0, 0, 0);
        model_reset();

        // asynchronous clear is visible before the first clock edge
        #2;
        chk("reset bcd",  32'(bcd),  32'h00);
        chk("reset zero", 32'(zero), 32'h1);
        chk("reset done", 32'(done), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        #18;
        reset = 1'b1;
        #1;
        compare_model("post-reset");

        // vector table
        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].pa, vecs[i].de);
            step("vec");
            chk($sformatf("vec%0d bcd", i),  32'(bcd),  32'(vecs[i].e_bcd));
            chk($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].e_done));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
        end

        // full countdown from 12
        drive(1, 8'h12, 0, 0, 0); step("cd load");
        drive(0, '0, 1, 0, 0);    step("cd start");
        chk("cd start bcd", 32'(bcd), 32'h12);
        drive(0, '0, 0, 0, 1);
        for (int n = 11; n >= 0; n--) begin
            step("cd tick");
            chk($sformatf("cd bcd@%0d", n),  32'(bcd),  32'(to_bcd(n)));
            chk($sformatf("cd done@%0d", n), 32'(done), 32'(n == 0));
            chk($sformatf("cd busy@%0d", n), 32'(busy), 32'(n != 0));
        end
        for (int n = 0; n < 20; n++) begin
            drive(0, '0, n[0], 0, 1);
            step("cd hold-zero");
            chk("cd stay bcd", 32'(bcd), 32'h00);
        end

        // pause while ticking
        drive(1, 8'h05, 0, 0, 0); step("pa load");
        drive(0, '0, 1, 0, 0);    step("pa start");
        for (int n = 0; n < 5; n++) begin
            drive(0, '0, 0, 1, 1);
            step("pa hold");
            chk("pa hold bcd",  32'(bcd),  32'h05);
            chk("pa hold busy", 32'(busy), 32'h1);
        end
        drive(0, '0, 1, 0, 1); step("pa resume");
        chk("pa resume bcd", 32'(bcd), 32'h05);
        drive(0, '0, 0, 0, 1); step("pa t1");
        chk("pa t1 bcd", 32'(bcd), 32'h04);
        step("pa t2");
        chk("pa t2 bcd", 32'(bcd), 32'h03);

        // start at zero after reset
        reset = 1'b0; model_reset(); #2; reset = 1'b1;
        drive(0, '0, 1, 0, 0); step("z start");
        chk("z start done", 32'(done), 32'h1);
        drive(0, '0, 0, 0, 0); step("z after");
        chk("z after done", 32'(done), 32'h0);
        drive(0, '0, 1, 0, 1); step("z restart");
        chk("z restart done", 32'(done), 32'h0);
        drive(1, 8'h02, 0, 0, 0); step("z load");
        chk("z load bcd", 32'(bcd), 32'h02);

        // asynchronous reset between edges while running at 07
        drive(1, 8'h07, 0, 0, 0); step("ar load");
        drive(0, '0, 1, 0, 0);    step("ar start");
        drive(0, '0, 0, 0, 0);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        chk("ar bcd",  32'(bcd),  32'h00);
        chk("ar busy", 32'(busy), 32'h0);
        chk("ar zero", 32'(zero), 32'h1);
        #1;
        reset = 1'b1;
        drive(1, 8'h03, 1, 0, 1); step("ar load+start");
        chk("ar ls bcd",  32'(bcd),  32'h03);
        chk("ar ls busy", 32'(busy), 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            drive(($urandom_range(0, 15) == 0), W'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0));
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule
